// File: rtl/s32x_video_mix_pkg.sv
// -----------------------------------------------------------------------------
// s32x_video_mix_pkg
// Shared types and helpers for the 32X video mixer:
//   RGB888_t            : 8-bit-per-channel colour triple
//   VMIX_ENTRY_t        : one MD dot as stored in the delay line (blank flags + colour)
//   vmix_layer_t        : layer override modes used by the optional debug input
//   EXP5TO8             : 5-bit to 8-bit colour expansion
//   VMIX_DLY_DEPTH_DEF  : default MD delay-line depth in dots
// -----------------------------------------------------------------------------
package s32x_video_mix_pkg;

    localparam int VMIX_DLY_DEPTH_DEF = 8;

    typedef struct packed {
        logic [7:0] R;
        logic [7:0] G;
        logic [7:0] B;
    } RGB888_t;

    typedef struct packed {
        logic    HBLK;
        logic    VBLK;
        RGB888_t RGB;
    } VMIX_ENTRY_t;

    localparam int VMIX_ENTRY_W = $bits(VMIX_ENTRY_t);

    localparam RGB888_t RGB_BLACK = '{R: 8'h00, G: 8'h00, B: 8'h00};
    localparam RGB888_t RGB_WHITE = '{R: 8'hFF, G: 8'hFF, B: 8'hFF};

    typedef enum logic [1:0] {
        LAYER_NORMAL = 2'b00,
        LAYER_MD     = 2'b01,
        LAYER_32X    = 2'b10,
        LAYER_MASK   = 2'b11
    } vmix_layer_t;

    // Replicate the top bits into the new LSBs so full scale maps to 0xFF.
    function automatic logic [7:0] EXP5TO8(input logic [4:0] x5);
        return {x5, x5[4:2]};
    endfunction

endpackage

// File: rtl/s32x_vmix_dline.sv
// -----------------------------------------------------------------------------
// s32x_vmix_dline
// Ring-buffer delay line advanced once per CE. DOUT is the entry written DLY
// CEs ago; DLY = 0 passes DIN straight through.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset (clears storage + pointer)
//   CE         : advance enable, one pulse per dot
//   DLY        : delay in dots, 0..DEPTH-1
//   DIN        : entry written this CE
//   DOUT       : delayed entry (combinational, sampled by the caller on CE)
// -----------------------------------------------------------------------------
module s32x_vmix_dline #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 26,
    localparam int AW    = $clog2(DEPTH)
)(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic [AW-1:0]    DLY,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rd_idx_s;

    // Read index relative to the not-yet-incremented write pointer; the
    // power-of-two depth lets the subtraction wrap for free. DLY never equals
    // DEPTH, so the slot being read is never the one being written.
    always_comb begin
        rd_idx_s = wptr_r - DLY;
        if (DLY == {AW{1'b0}}) begin
            DOUT = DIN;
        end else begin
            DOUT = mem_r[rd_idx_s];
        end
    end

    // Storage write and pointer advance on each dot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wptr_r <= {AW{1'b0}};
        end else if (CE) begin
            mem_r[wptr_r] <= DIN;
            wptr_r        <= wptr_r + PTR_ONE;
        end
    end

endmodule

// File: rtl/s32x_video_mix.sv
// -----------------------------------------------------------------------------
// s32x_video_mix
// Final mixing stage behind the 32X VDP. Delays the MD pixel stream by MD_DLY
// dots, picks the 32X or MD layer per dot from S32X_YSO_N, expands 32X colour
// to 8 bits, forces black in blanking and registers colour/sync/blank outputs
// one dot after the 32X inputs. S32X_ACTIVE reports whether any 32X dot was
// visible during the previous frame (frames delimited by VS_N falling edges).
//
// Ports:
//   CLK, RST_N              : clock, asynchronous active-low reset
//   CE_PIX                  : dot clock enable
//   MD_R/G/B, MD_HBLK/VBLK  : MD pixel stream and blanking
//   S32X_R/G/B (5b)         : 32X colour
//   S32X_YSO_N              : 0 = show 32X dot, 1 = show MD dot
//   S32X_HS_N / S32X_VS_N   : syncs from the VDP
//   MD_DLY                  : MD path delay in dots
//   DBG_LAYER               : layer override, only with S32X_VMIX_LAYER_DBG_EN
//   R/G/B, HS_N/VS_N,
//   HBLK/VBLK               : mixed, aligned video out
//   CE_OUT                  : CE_PIX delayed one CLK
//   S32X_ACTIVE             : a 32X dot was visible in the previous frame
//
// Optional build macro: S32X_VMIX_LAYER_DBG_EN adds the DBG_LAYER input.
// -----------------------------------------------------------------------------
module s32x_video_mix
    import s32x_video_mix_pkg::*;
#(
    parameter int  DLY_DEPTH = VMIX_DLY_DEPTH_DEF,
    localparam int DLY_AW    = $clog2(DLY_DEPTH)
)(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE_PIX,
    input  logic [7:0]        MD_R,
    input  logic [7:0]        MD_G,
    input  logic [7:0]        MD_B,
    input  logic              MD_HBLK,
    input  logic              MD_VBLK,
    input  logic [4:0]        S32X_R,
    input  logic [4:0]        S32X_G,
    input  logic [4:0]        S32X_B,
    input  logic              S32X_YSO_N,
    input  logic              S32X_HS_N,
    input  logic              S32X_VS_N,
    input  logic [DLY_AW-1:0] MD_DLY,
`ifdef S32X_VMIX_LAYER_DBG_EN
    input  logic [1:0]        DBG_LAYER,
`endif
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              HS_N,
    output logic              VS_N,
    output logic              HBLK,
    output logic              VBLK,
    output logic              CE_OUT,
    output logic              S32X_ACTIVE
);

    VMIX_ENTRY_t              md_live_s;
    VMIX_ENTRY_t              md_dly_s;
    logic [VMIX_ENTRY_W-1:0]  dline_out_s;
    RGB888_t                  x32_s;
    RGB888_t                  pick_s;
    RGB888_t                  mix_s;
    vmix_layer_t              layer_s;
    logic                     blank_s;
    logic                     hit_s;
    logic                     vs_fall_s;

    RGB888_t                  rgb_r;
    logic                     hs_n_r;
    logic                     vs_n_r;
    logic                     hblk_r;
    logic                     vblk_r;
    logic                     ce_out_r;
    logic                     seen_r;
    logic                     active_r;

    // Pack the live MD dot into a delay-line entry.
    always_comb begin
        md_live_s.HBLK  = MD_HBLK;
        md_live_s.VBLK  = MD_VBLK;
        md_live_s.RGB.R = MD_R;
        md_live_s.RGB.G = MD_G;
        md_live_s.RGB.B = MD_B;
    end

    s32x_vmix_dline #(
        .DEPTH (DLY_DEPTH),
        .WIDTH (VMIX_ENTRY_W)
    ) u_dline (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CE    (CE_PIX),
        .DLY   (MD_DLY),
        .DIN   (md_live_s),
        .DOUT  (dline_out_s)
    );

    assign md_dly_s = dline_out_s;

    // Layer selection, blanking and frame-hit detection for the current dot.
    always_comb begin
        x32_s.R = EXP5TO8(S32X_R);
        x32_s.G = EXP5TO8(S32X_G);
        x32_s.B = EXP5TO8(S32X_B);

`ifdef S32X_VMIX_LAYER_DBG_EN
        layer_s = vmix_layer_t'(DBG_LAYER);
`else
        layer_s = LAYER_NORMAL;
`endif

        blank_s = md_dly_s.HBLK | md_dly_s.VBLK;
        // Hit uses the real YSO_N so debug overrides never affect S32X_ACTIVE.
        hit_s   = ~S32X_YSO_N & ~blank_s;
        // vs_n_r holds the previous dot's VS_N, so this is the falling edge.
        vs_fall_s = vs_n_r & ~S32X_VS_N;

        case (layer_s)
            LAYER_NORMAL: begin
                if (S32X_YSO_N) begin
                    pick_s = md_dly_s.RGB;
                end else begin
                    pick_s = x32_s;
                end
            end
            LAYER_MD:  pick_s = md_dly_s.RGB;
            LAYER_32X: pick_s = x32_s;
            LAYER_MASK: begin
                if (S32X_YSO_N) begin
                    pick_s = RGB_BLACK;
                end else begin
                    pick_s = RGB_WHITE;
                end
            end
            default:   pick_s = RGB_BLACK;
        endcase

        if (blank_s) begin
            mix_s = RGB_BLACK;
        end else begin
            mix_s = pick_s;
        end
    end

    // Output video register, one dot behind the 32X inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rgb_r  <= RGB_BLACK;
            hblk_r <= 1'b1;
            vblk_r <= 1'b1;
            hs_n_r <= 1'b1;
            vs_n_r <= 1'b1;
        end else if (CE_PIX) begin
            rgb_r  <= mix_s;
            hblk_r <= md_dly_s.HBLK;
            vblk_r <= md_dly_s.VBLK;
            hs_n_r <= S32X_HS_N;
            vs_n_r <= S32X_VS_N;
        end
    end

    // Dot-enable copy for the downstream pipeline.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ce_out_r <= 1'b0;
        end else begin
            ce_out_r <= CE_PIX;
        end
    end

    // Per-frame visibility: a hit on the edge dot still belongs to the closing frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seen_r   <= 1'b0;
            active_r <= 1'b0;
        end else if (CE_PIX) begin
            if (vs_fall_s) begin
                active_r <= seen_r | hit_s;
                seen_r   <= 1'b0;
            end else if (hit_s) begin
                seen_r   <= 1'b1;
            end
        end
    end

    assign R           = rgb_r.R;
    assign G           = rgb_r.G;
    assign B           = rgb_r.B;
    assign HBLK        = hblk_r;
    assign VBLK        = vblk_r;
    assign HS_N        = hs_n_r;
    assign VS_N        = vs_n_r;
    assign CE_OUT      = ce_out_r;
    assign S32X_ACTIVE = active_r;

endmodule

// File: tb/tb_s32x_video_mix.sv
// -----------------------------------------------------------------------------
// tb_s32x_video_mix
// Self-checking bench for s32x_video_mix. A reference model keeps the full
// history of MD dots in a queue and looks back MD_DLY entries, applying the
// selection/blanking/frame rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_s32x_video_mix;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       CE_PIX;
    logic [7:0] MD_R, MD_G, MD_B;
    logic       MD_HBLK, MD_VBLK;
    logic [4:0] S32X_R, S32X_G, S32X_B;
    logic       S32X_YSO_N, S32X_HS_N, S32X_VS_N;
    logic [2:0] MD_DLY;
`ifdef S32X_VMIX_LAYER_DBG_EN
    logic [1:0] DBG_LAYER = 2'b00;
`endif
    logic [7:0] R, G, B;
    logic       HS_N, VS_N, HBLK, VBLK, CE_OUT, S32X_ACTIVE;

    s32x_video_mix #(.DLY_DEPTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_PIX(CE_PIX),
        .MD_R(MD_R), .MD_G(MD_G), .MD_B(MD_B),
        .MD_HBLK(MD_HBLK), .MD_VBLK(MD_VBLK),
        .S32X_R(S32X_R), .S32X_G(S32X_G), .S32X_B(S32X_B),
        .S32X_YSO_N(S32X_YSO_N), .S32X_HS_N(S32X_HS_N), .S32X_VS_N(S32X_VS_N),
        .MD_DLY(MD_DLY),
`ifdef S32X_VMIX_LAYER_DBG_EN
        .DBG_LAYER(DBG_LAYER),
`endif
        .R(R), .G(G), .B(B), .HS_N(HS_N), .VS_N(VS_N),
        .HBLK(HBLK), .VBLK(VBLK), .CE_OUT(CE_OUT), .S32X_ACTIVE(S32X_ACTIVE)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [25:0] hist[$];
    logic [23:0] exp_rgb;
    logic        exp_hblk, exp_vblk, exp_hs, exp_vs, exp_active;
    logic        seen_m, prev_vs_m;

    logic [29:0] obs;
    assign obs = {R, G, B, HBLK, VBLK, HS_N, VS_N, CE_OUT, S32X_ACTIVE};

    function automatic logic [7:0] exp5(input int x);
        int v;
        v = x * 8 + x / 4;
        return v[7:0];
    endfunction

    function automatic logic [29:0] exp_vec(input logic ce);
        return {exp_rgb, exp_hblk, exp_vblk, exp_hs, exp_vs, ce, exp_active};
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_rgb    = 24'h0;
        exp_hblk   = 1'b1;
        exp_vblk   = 1'b1;
        exp_hs     = 1'b1;
        exp_vs     = 1'b1;
        exp_active = 1'b0;
        seen_m     = 1'b0;
        prev_vs_m  = 1'b1;
    endtask

    task automatic idle();
        CE_PIX = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // One dot: drive inputs, pulse CE for one CLK, then advance the model.
    task automatic dot(input logic [25:0] md, input logic yso,
                       input logic [4:0] xr, input logic [4:0] xg, input logic [4:0] xb,
                       input logic hs, input logic vs);
        logic [25:0] e;
        int          d, n;
        logic        blank, hit;
        {MD_HBLK, MD_VBLK, MD_R, MD_G, MD_B} = md;
        S32X_YSO_N = yso;
        S32X_R = xr; S32X_G = xg; S32X_B = xb;
        S32X_HS_N = hs; S32X_VS_N = vs;
        CE_PIX = 1'b1;
        @(posedge CLK);
        #1;
        CE_PIX = 1'b0;
        d = int'(MD_DLY);
        n = hist.size();
        if (d == 0)          e = md;
        else if (n - d >= 0) e = hist[n - d];
        else                 e = 26'h0;
        hist.push_back(md);
        blank = e[25] | e[24];
        if (blank)     exp_rgb = 24'h0;
        else if (!yso) exp_rgb = {exp5(int'(xr)), exp5(int'(xg)), exp5(int'(xb))};
        else           exp_rgb = e[23:0];
        exp_hblk = e[25];
        exp_vblk = e[24];
        exp_hs   = hs;
        exp_vs   = vs;
        hit = !yso && !blank;
        if (prev_vs_m && !vs) begin
            exp_active = seen_m | hit;
            seen_m     = 1'b0;
        end else if (hit) begin
            seen_m = 1'b1;
        end
        prev_vs_m = vs;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (obs !== exp_vec(1'b0)) begin
            $display("FAIL reset_state: got %h want %h", obs, exp_vec(1'b0)); n_fail++;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        idle();
        n_cmp++;
        if (CE_OUT !== 1'b0) begin
            $display("FAIL ce_out_idle: got %b want 0", CE_OUT); n_fail++;
        end
        dot({2'b00, 24'h123456}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        n_cmp++;
        if (obs !== exp_vec(1'b1)) begin
            $display("FAIL first_ce: got %h want %h", obs, exp_vec(1'b1)); n_fail++;
        end
        idle();
        n_cmp++;
        if (obs !== exp_vec(1'b0)) begin
            $display("FAIL hold_after_ce: got %h want %h", obs, exp_vec(1'b0)); n_fail++;
        end
    endtask

    task automatic test_md_delay();
        MD_DLY = 3'd0;
        dot({2'b00, 24'h5A0000}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        n_cmp++;
        if (R !== 8'h5A || obs !== exp_vec(1'b1)) begin
            $display("FAIL dly0_r: got %h want %h (R=%h want 5a)", obs, exp_vec(1'b1), R); n_fail++;
        end
        MD_DLY = 3'd3;
        dot({2'b00, 24'h5A0000}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== exp_vec(1'b1)) begin
                $display("FAIL dly3_step%0d: got %h want %h", i, obs, exp_vec(1'b1)); n_fail++;
            end
            dot({2'b00, 24'h111111}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        end
        n_cmp++;
        if (R !== 8'h5A || obs !== exp_vec(1'b1)) begin
            $display("FAIL dly3_r: got %h want %h (R=%h want 5a)", obs, exp_vec(1'b1), R); n_fail++;
        end
    endtask

    task automatic test_s32x_expand();
        logic [2:0] dl [3];
        dl[0] = 3'd0; dl[1] = 3'd3; dl[2] = 3'd7;
        for (int k = 0; k < 3; k++) begin
            MD_DLY = dl[k];
            dot({2'b00, 24'($urandom)}, 1'b0, 5'd31, 5'd16, 5'd1, 1'b1, 1'b1);
            n_cmp++;
            if ({R, G, B} !== 24'hFF8408 || obs !== exp_vec(1'b1)) begin
                $display("FAIL expand_dly%0d: got %h want %h (rgb=%h want ff8408)",
                         dl[k], obs, exp_vec(1'b1), {R, G, B}); n_fail++;
            end
        end
    endtask

    task automatic test_blank();
        int cnt;
        MD_DLY = 3'd0;
        dot({2'b00, 24'h010203}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dot({2'b10, 24'hABCDEF}, 1'b0, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1);
            n_cmp++;
            if ({R, G, B} !== 24'h0 || obs !== exp_vec(1'b1)) begin
                $display("FAIL blank_black%0d: got %h want %h", i, obs, exp_vec(1'b1)); n_fail++;
            end
        end
        dot({2'b10, 24'hABCDEF}, 1'b0, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0);
        n_cmp++;
        if (S32X_ACTIVE !== 1'b0 || obs !== exp_vec(1'b1)) begin
            $display("FAIL blank_no_credit: got %h want %h", obs, exp_vec(1'b1)); n_fail++;
        end
        MD_DLY = 3'd2;
        for (int i = 0; i < 3; i++) dot({2'b00, 24'h202020}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 1; i <= 10 && cnt == 0; i++) begin
            dot({2'b10, 24'h303030}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
            if (HBLK === 1'b1) cnt = i;
        end
        n_cmp++;
        if (cnt != 3) begin
            $display("FAIL hblk_latency: got %0d CEs want 3", cnt); n_fail++;
        end
    endtask

    task automatic test_frame_status();
        MD_DLY = 3'd0;
        for (int i = 0; i < 12; i++)
            dot({2'b00, 24'h445566}, (i == 5) ? 1'b0 : 1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
        dot({2'b00, 24'h445566}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        n_cmp++;
        if (S32X_ACTIVE !== 1'b1 || obs !== exp_vec(1'b1)) begin
            $display("FAIL frame_active: got %h want %h", obs, exp_vec(1'b1)); n_fail++;
        end
        for (int i = 0; i < 3; i++) dot({2'b00, 24'h0}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) dot({2'b00, 24'h778899}, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1);
        dot({2'b00, 24'h778899}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        n_cmp++;
        if (S32X_ACTIVE !== 1'b0 || obs !== exp_vec(1'b1)) begin
            $display("FAIL frame_inactive: got %h want %h", obs, exp_vec(1'b1)); n_fail++;
        end
        for (int i = 0; i < 4; i++) dot({2'b00, 24'h1}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        dot({2'b00, 24'h1}, 1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0);
        n_cmp++;
        if (S32X_ACTIVE !== 1'b1 || obs !== exp_vec(1'b1)) begin
            $display("FAIL frame_edge_hit: got %h want %h", obs, exp_vec(1'b1)); n_fail++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        MD_DLY = 3'd7;
        for (int i = 0; i < 20; i++) begin
            v = 8'(i);
            dot({2'b00, v, v, v}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
            n_cmp++;
            if (obs !== exp_vec(1'b1) || (i >= 7 && R !== 8'(i - 7))) begin
                $display("FAIL wrap_ramp%0d: got %h want %h (R=%0d)", i, obs, exp_vec(1'b1), R);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        CE_PIX = 1'b1;
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs !== exp_vec(1'b0)) begin
            $display("FAIL midframe_reset: got %h want %h", obs, exp_vec(1'b0)); n_fail++;
        end
        CE_PIX = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        idle();
        MD_DLY = 3'd3;
        dot({2'b00, 24'hC0FFEE}, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        n_cmp++;
        if ({R, G, B} !== 24'h0 || obs !== exp_vec(1'b1)) begin
            $display("FAIL post_reset_clean: got %h want %h", obs, exp_vec(1'b1)); n_fail++;
        end
    endtask

    task automatic test_random();
        logic vs_s = 1'b1;
        logic hs_s = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) MD_DLY = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) vs_s = ~vs_s;
            if ($urandom_range(0, 9) == 0)  hs_s = ~hs_s;
            if ($urandom_range(0, 3) == 0) begin
                idle();
                n_cmp++;
                if (obs !== exp_vec(1'b0)) begin
                    $display("FAIL rand_idle%0d: got %h want %h", i, obs, exp_vec(1'b0)); n_fail++;
                end
            end else begin
                dot({($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 24'($urandom)},
                    1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 5'($urandom), hs_s, vs_s);
                n_cmp++;
                if (obs !== exp_vec(1'b1)) begin
                    $display("FAIL rand_dot%0d: got %h want %h", i, obs, exp_vec(1'b1)); n_fail++;
                end
            end
        end
    endtask

    initial begin
        RST_N = 1'b0; CE_PIX = 1'b0; MD_DLY = 3'd0;
        MD_R = 8'h0; MD_G = 8'h0; MD_B = 8'h0; MD_HBLK = 1'b0; MD_VBLK = 1'b0;
        S32X_R = 5'd0; S32X_G = 5'd0; S32X_B = 5'd0;
        S32X_YSO_N = 1'b1; S32X_HS_N = 1'b1; S32X_VS_N = 1'b1;
        model_reset();
        test_reset();
        test_md_delay();
        test_s32x_expand();
        test_blank();
        test_frame_status();
        test_wrap();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
